cc_branch_unit: RTL and testbench

- Consumer of mini_alu `flags` {N,Z,V,C}.
- Holds the integer condition codes (icc) and evaluates the SPARC Bicc condition field.
- Sequences the delay slot that follows each branch, including annul handling.
- Issues a one-cycle redirect of the target PC to fetch.

---
 rtl/cc_pkg.sv | 32 +++
 rtl/cc_cond_eval.sv | 40 ++++
 rtl/cc_branch_unit.sv | 123 ++++++++++++
 tb/tb_cc_branch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the branch unit: icc flag positions, Bicc condition
// codes and the delay-slot sequencer states.
package cc_pkg;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int C_BIT = 0;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational Bicc/Ticc condition evaluator: cond field plus {N,Z,V,C}
// gives taken. The upper cond bit inverts the base test.
module cc_cond_eval
    import cc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzvc,
    output logic       taken
);

    logic n_s;
    logic z_s;
    logic v_s;
    logic c_s;
    logic base_s;

    assign n_s = nzvc[N_BIT];
    assign z_s = nzvc[Z_BIT];
    assign v_s = nzvc[V_BIT];
    assign c_s = nzvc[C_BIT];

    // Base condition selected by the low three cond bits.
    always_comb begin
        base_s = 1'b0;
        case (cond[2:0])
            3'b000:  base_s = 1'b0;
            3'b001:  base_s = z_s;
            3'b010:  base_s = z_s | (n_s ^ v_s);
            3'b011:  base_s = n_s ^ v_s;
            3'b100:  base_s = c_s | z_s;
            3'b101:  base_s = c_s;
            3'b110:  base_s = n_s;
            3'b111:  base_s = v_s;
            default: base_s = 1'b0;
        endcase
    end

    assign taken = base_s ^ cond[3];

endmodule

// File: rtl/cc_branch_unit.sv
// Integer condition codes, Bicc evaluation and delay-slot sequencing with a
// one-cycle fetch redirect. Option CC_BYPASS_EN forwards flags_in to the
// condition when a cc write coincides with a branch.
module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        flags_in,
    input  logic              cc_we,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic              br_annul,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              slot_valid,
    output logic              slot_annul,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [3:0]        icc
);

    cc_state_e         state_q, state_d;
    logic              taken_q, taken_d;
    logic              annul_q, annul_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [3:0]        icc_q, icc_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic [3:0]        eval_nzvc_s;
    logic              taken_s;
    logic              cc_squash_s;

`ifdef CC_BYPASS_EN
    assign eval_nzvc_s = (cc_we && br_valid && (state_q == IDLE)) ? flags_in : icc_q;
`else
    assign eval_nzvc_s = icc_q;
`endif

    cc_cond_eval u_cond_eval (
        .cond  (br_cond),
        .nzvc  (eval_nzvc_s),
        .taken (taken_s)
    );

    // A squashed delay-slot instruction must not touch icc.
    assign cc_squash_s = (state_q == SLOT) && annul_q && slot_valid;

    // Next-state for the slot sequencer, latched branch info, redirect and icc.
    always_comb begin
        state_d       = state_q;
        taken_d       = taken_q;
        annul_d       = annul_q;
        target_d      = target_q;
        icc_d         = icc_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    taken_d  = taken_s;
                    annul_d  = br_annul & (~taken_s | (br_cond == COND_BA));
                    target_d = br_target;
                    state_d  = SLOT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SLOT: begin
                if (slot_valid) begin
                    state_d = IDLE;
                    if (taken_q) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = target_q;
                    end else begin
                        redirect_d    = 1'b0;
                    end
                end else begin
                    state_d = SLOT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cc_we && !cc_squash_s) begin
            icc_d = flags_in;
        end else begin
            icc_d = icc_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            taken_q       <= 1'b0;
            annul_q       <= 1'b0;
            target_q      <= {ADDR_W{1'b0}};
            icc_q         <= 4'b0000;
            redirect_q    <= 1'b0;
            redirect_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            taken_q       <= taken_d;
            annul_q       <= annul_d;
            target_q      <= target_d;
            icc_q         <= icc_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign br_ready    = (state_q == IDLE);
    assign slot_annul  = (state_q == SLOT) && annul_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign icc         = icc_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Self-checking bench for cc_branch_unit: directed vector table, full
// cond x icc sweep, randomized transactions against a reference model.
module tb_cc_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  flags_in;
    logic        cc_we;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic        br_annul;
    logic [31:0] br_target;
    logic        slot_valid;
    logic        slot_annul;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [3:0]  icc;

    int total;
    int bad;

    cc_branch_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flags_in    (flags_in),
        .cc_we       (cc_we),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_cond     (br_cond),
        .br_annul    (br_annul),
        .br_target   (br_target),
        .slot_valid  (slot_valid),
        .slot_annul  (slot_annul),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .icc         (icc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond;
        logic        annul;
        logic [3:0]  icc_v;
        logic [31:0] tgt;
        logic        exp_sa;
        logic        exp_rd;
    } vec_t;

    // Truth table for Bicc, written out per condition mnemonic.
    function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'd0:  return 1'b0;
            4'd1:  return z;
            4'd2:  return z | (n ^ v);
            4'd3:  return n ^ v;
            4'd4:  return cy | z;
            4'd5:  return cy;
            4'd6:  return n;
            4'd7:  return v;
            4'd8:  return 1'b1;
            4'd9:  return !z;
            4'd10: return !(z | (n ^ v));
            4'd11: return !(n ^ v);
            4'd12: return !(cy | z);
            4'd13: return !cy;
            4'd14: return !n;
            default: return !v;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_icc(input logic [3:0] v);
        cc_we = 1'b1;
        flags_in = v;
        step();
        cc_we = 1'b0;
    endtask

    task automatic run_branch(input logic [3:0] c, input logic a, input logic [31:0] tgt,
                              input int stall, input logic slot_we, input logic [3:0] slot_fl,
                              output logic sa, output logic rd, output logic [31:0] rpc,
                              output logic rd2);
        br_valid = 1'b1;
        br_cond = c;
        br_annul = a;
        br_target = tgt;
        step();
        br_valid = 1'b0;
        sa = slot_annul;
        repeat (stall) step();
        slot_valid = 1'b1;
        cc_we = slot_we;
        flags_in = slot_fl;
        step();
        slot_valid = 1'b0;
        cc_we = 1'b0;
        rd = redirect;
        rpc = redirect_pc;
        step();
        rd2 = redirect;
    endtask

    initial begin
        vec_t        vecs[8];
        logic        sa, rd, rd2, t, esa;
        logic [31:0] rpc;
        logic [3:0]  icc_m;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        flags_in = 4'b0000;
        cc_we = 1'b0;
        br_valid = 1'b0;
        br_cond = 4'b0000;
        br_annul = 1'b0;
        br_target = 32'h0;
        slot_valid = 1'b0;

        vecs[0] = '{4'b0001, 1'b0, 4'b0100, 32'h0000_0040, 1'b0, 1'b1};
        vecs[1] = '{4'b0001, 1'b1, 4'b0000, 32'h0000_0044, 1'b1, 1'b0};
        vecs[2] = '{4'b1000, 1'b1, 4'b0000, 32'h0000_0100, 1'b1, 1'b1};
        vecs[3] = '{4'b0000, 1'b0, 4'b0000, 32'h0000_0200, 1'b0, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 4'b1111, 32'h0000_0204, 1'b1, 1'b0};
        vecs[5] = '{4'b1010, 1'b1, 4'b0000, 32'h0000_0300, 1'b0, 1'b1};
        vecs[6] = '{4'b0011, 1'b0, 4'b1000, 32'h0000_0400, 1'b0, 1'b1};
        vecs[7] = '{4'b0101, 1'b1, 4'b0001, 32'h0000_0500, 1'b0, 1'b1};

        #12;
        check("rst_icc", {28'h0, icc}, 32'h0);
        check("rst_redirect", {31'h0, redirect}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_slot_annul", {31'h0, slot_annul}, 32'h0);
        check("rst_br_ready", {31'h0, br_ready}, 32'h1);
        rst_n = 1'b1;
        step();

        set_icc(4'b0100);
        check("icc_write", {28'h0, icc}, 32'h4);

        foreach (vecs[i]) begin
            set_icc(vecs[i].icc_v);
            run_branch(vecs[i].cond, vecs[i].annul, vecs[i].tgt, 0, 1'b0, 4'b0000, sa, rd, rpc, rd2);
            check($sformatf("vec%0d_slot_annul", i), {31'h0, sa}, {31'h0, vecs[i].exp_sa});
            check($sformatf("vec%0d_redirect", i), {31'h0, rd}, {31'h0, vecs[i].exp_rd});
            if (vecs[i].exp_rd) check($sformatf("vec%0d_redirect_pc", i), rpc, vecs[i].tgt);
            check($sformatf("vec%0d_redirect_pulse", i), {31'h0, rd2}, 32'h0);
        end

        // Annulled slot carrying a cc write must leave icc untouched.
        set_icc(4'b0000);
        run_branch(4'b0001, 1'b1, 32'h60, 0, 1'b1, 4'b1111, sa, rd, rpc, rd2);
        check("squash_slot_annul", {31'h0, sa}, 32'h1);
        check("squash_icc", {28'h0, icc}, 32'h0);
        check("squash_redirect", {31'h0, rd}, 32'h0);

        // Coincident cc write and BNE.
        set_icc(4'b0000);
        br_valid = 1'b1; br_cond = 4'b1001; br_annul = 1'b1; br_target = 32'h70;
        cc_we = 1'b1; flags_in = 4'b0100;
        step();
        br_valid = 1'b0; cc_we = 1'b0;
`ifdef CC_BYPASS_EN
        t = 1'b0;
`else
        t = 1'b1;
`endif
        check("bypass_icc", {28'h0, icc}, 32'h4);
        check("bypass_slot_annul", {31'h0, slot_annul}, {31'h0, !t});
        slot_valid = 1'b1;
        step();
        slot_valid = 1'b0;
        check("bypass_redirect", {31'h0, redirect}, {31'h0, t});
        step();

        for (int c = 0; c < 16; c++) begin
            for (int v = 0; v < 16; v++) begin
                logic a;
                a = logic'(c[0] ^ v[0]);
                set_icc(4'(v));
                run_branch(4'(c), a, 32'h1000 + 32'(c * 16 + v), 0, 1'b0, 4'b0000, sa, rd, rpc, rd2);
                t = ref_taken(4'(c), 4'(v));
                esa = a & (!t | (c == 8));
                check($sformatf("sweep_c%0d_f%0d_rd", c, v), {31'h0, rd}, {31'h0, t});
                check($sformatf("sweep_c%0d_f%0d_sa", c, v), {31'h0, sa}, {31'h0, esa});
                if (t) check($sformatf("sweep_c%0d_f%0d_pc", c, v), rpc, 32'h1000 + 32'(c * 16 + v));
            end
        end

        // Stall in SLOT with a second branch pending, plus an independent cc write.
        set_icc(4'b0000);
        br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b1; br_target = 32'h200;
        step();
        br_cond = 4'b0000; br_annul = 1'b0; br_target = 32'h300;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_br_ready", k), {31'h0, br_ready}, 32'h0);
            check($sformatf("stall%0d_slot_annul", k), {31'h0, slot_annul}, 32'h1);
            check($sformatf("stall%0d_redirect", k), {31'h0, redirect}, 32'h0);
            cc_we = (k == 2);
            flags_in = 4'b0011;
            step();
        end
        cc_we = 1'b0;
        check("stall_cc_write", {28'h0, icc}, 32'h3);
        br_valid = 1'b0;
        slot_valid = 1'b1;
        step();
        slot_valid = 1'b0;
        check("stall_redirect", {31'h0, redirect}, 32'h1);
        check("stall_redirect_pc", redirect_pc, 32'h200);
        step();
        check("stall_redirect_pulse", {31'h0, redirect}, 32'h0);
        check("stall_second_ignored", {31'h0, br_ready}, 32'h1);

        // Reset while a taken branch waits for its slot.
        set_icc(4'b0101);
        br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b0; br_target = 32'h500;
        step();
        br_valid = 1'b0;
        check("midrst_in_slot", {31'h0, br_ready}, 32'h0);
        rst_n = 1'b0;
        #2;
        check("midrst_icc", {28'h0, icc}, 32'h0);
        check("midrst_br_ready", {31'h0, br_ready}, 32'h1);
        check("midrst_redirect", {31'h0, redirect}, 32'h0);
        rst_n = 1'b1;
        slot_valid = 1'b1;
        step();
        slot_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst_no_redirect%0d", k), {31'h0, redirect}, 32'h0);
            step();
        end

        icc_m = icc;
        check("rand_icc_start", {28'h0, icc}, 32'h0);
        for (int it = 0; it < 200; it++) begin
            logic [3:0]  c, fl;
            logic        a, we;
            logic [31:0] tgt;
            int          st;
            if ($urandom_range(1, 0) == 1) begin
                fl = 4'($urandom_range(15, 0));
                set_icc(fl);
                icc_m = fl;
            end
            c = 4'($urandom_range(15, 0));
            a = 1'($urandom_range(1, 0));
            tgt = $urandom;
            st = $urandom_range(3, 0);
            we = 1'($urandom_range(1, 0));
            fl = 4'($urandom_range(15, 0));
            run_branch(c, a, tgt, st, we, fl, sa, rd, rpc, rd2);
            t = ref_taken(c, icc_m);
            esa = a & (!t | (c == 4'b1000));
            if (we && !esa) icc_m = fl;
            check($sformatf("rand%0d_sa", it), {31'h0, sa}, {31'h0, esa});
            check($sformatf("rand%0d_rd", it), {31'h0, rd}, {31'h0, t});
            if (t) check($sformatf("rand%0d_pc", it), rpc, tgt);
            check($sformatf("rand%0d_pulse", it), {31'h0, rd2}, 32'h0);
            check($sformatf("rand%0d_icc", it), {28'h0, icc}, {28'h0, icc_m});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
